aes256_dec_iter: RTL

Iterative AES-256 decryptor (FIPS-197 inverse cipher, ECB primitive): the decrypt-side counterpart of the pipelined AES-256 encryption datapath.
- Expands a 256-bit key once into 15 round keys held in a local register file.
- Decrypts one 128-bit block per 14 round cycles, one round per cycle.
- Valid/ready on both data sides. Used for ECB decrypt and key-wrap paths where encrypt-pipeline throughput is unnecessary.

---
 rtl/aes_pkg.sv | 94 +++++++++
 rtl/aes_inv_round.sv | 49 ++++
 rtl/aes256_dec_iter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES arithmetic, key-schedule step and controller state encoding.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    READY = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } aesState_e;

  // Multiply by x modulo 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add over the bits of b
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse
  function automatic logic [7:0] invSbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant for even key steps; k = step index / 2
  function automatic logic [7:0] rcon(input logic [2:0] k);
    case (k)
      3'd1:    return 8'h01;
      3'd2:    return 8'h02;
      3'd3:    return 8'h04;
      3'd4:    return 8'h08;
      3'd5:    return 8'h10;
      3'd6:    return 8'h20;
      3'd7:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  // One 128-bit step of the AES-256 schedule: rk[i] from rk[i-2], rk[i-1]
  function automatic logic [127:0] keyStep(input logic [127:0] prev2,
                                           input logic [127:0] prev1,
                                           input logic isEven,
                                           input logic [7:0] rc);
    logic [31:0] w;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;
    w = prev1[31:0];
    if (isEven) t = subWord({w[23:0], w[31:24]}) ^ {rc, 24'h000000};
    else        t = subWord(w);
    w0 = prev2[127:96] ^ t;
    w1 = prev2[95:64]  ^ w0;
    w2 = prev2[63:32]  ^ w1;
    w3 = prev2[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
module aes_inv_round (
  input  logic [127:0] stateIn,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] stateOut
);
  import aes_pkg::*;

  logic [127:0] afterKey;

  // Byte (r,c) lives at index r + 4c, byte 0 in the top bits
  function automatic logic [127:0] invShiftSub(input logic [127:0] v);
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[127 - 8*(r + 4*c) -: 8] = invSbox(v[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] invMix(input logic [127:0] v);
    logic [127:0] res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127 - 32*c -: 8];
      a1 = v[119 - 32*c -: 8];
      a2 = v[111 - 32*c -: 8];
      a3 = v[103 - 32*c -: 8];
      res[127 - 32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return res;
  endfunction

  // Full inverse round; the final round leaves the column mix out
  always_comb begin
    afterKey = invShiftSub(stateIn) ^ rk;
    stateOut = last ? afterKey : invMix(afterKey);
  end

endmodule

// File: rtl/aes256_dec_iter.sv
// Iterative AES-256 decryptor: on-chip key expansion into a 15-entry
// round-key file, then one inverse round per enabled cycle.
//
// Handshakes: a transfer happens on a rising edge where valid & ready & cen
// are all high. in_ready is only high in READY with cen high and no key_load
// pending (key_load wins over an input). out_valid/dout stay stable until
// the transfer; with cen low nothing transfers.
module aes256_dec_iter #(
  parameter int NR       = 14,
  parameter bit RK_RESET = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cen,
  input  logic         key_load,
  input  logic [255:0] key,
  output logic         key_busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic [2:0]   dbgState
);
  import aes_pkg::*;

  if (NR != 14) begin : gBadNr
    $error("aes256_dec_iter: NR must be 14 for AES-256");
  end

  localparam logic [3:0] LAST_RK   = 4'(NR);
  localparam logic [3:0] FIRST_RND = 4'(NR - 1);

  aesState_e    state, stateNext;
  // Shared index: key-file write slot during KEXP, round number during ROUND
  logic [3:0]   rnd;
  logic [127:0] s;
  logic [127:0] rkFile [0:NR];
  logic [127:0] roundOut;
  logic [127:0] rkNext;
  logic         rkLoad, rkStep;

  assign dbgState = state;
  assign rkLoad   = cen & key_load;
  assign rkStep   = cen & ~key_load & (state == KEXP);
  assign rkNext   = keyStep(rkFile[rnd - 4'd2], rkFile[rnd - 4'd1], ~rnd[0], rcon(rnd[3:1]));

  aes_inv_round uRound (
    .stateIn (s),
    .rk      (rkFile[rnd]),
    .last    (rnd == 4'd0),
    .stateOut(roundOut)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state and handshake/status outputs
  always_comb begin
    stateNext = state;
    key_busy  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      KEXP:    key_busy  = 1'b1;
      READY:   in_ready  = cen & ~key_load;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
    if (cen) begin
      if (key_load) begin
        stateNext = KEXP;
      end else begin
        case (state)
          KEXP:    if (rnd == LAST_RK) stateNext = READY;
          READY:   if (in_valid)       stateNext = ROUND;
          ROUND:   if (rnd == 4'd0)    stateNext = OUT;
          OUT:     if (out_ready)      stateNext = READY;
          default: ;
        endcase
      end
    end
  end

  // Block state, round counter and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s    <= '0;
      rnd  <= 4'd0;
      dout <= '0;
    end else if (cen) begin
      if (key_load) begin
        rnd <= 4'd2;
      end else begin
        case (state)
          KEXP:  if (rnd != LAST_RK) rnd <= rnd + 4'd1;
          READY: if (in_valid) begin
                   s   <= din ^ rkFile[NR];
                   rnd <= FIRST_RND;
                 end
          ROUND: begin
                   s <= roundOut;
                   if (rnd == 4'd0) dout <= roundOut;
                   else             rnd  <= rnd - 4'd1;
                 end
          default: ;
        endcase
      end
    end
  end

  if (RK_RESET) begin : gRkReset
    // Round-key file, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i <= NR; i++) rkFile[i] <= '0;
      end else if (rkLoad) begin
        rkFile[0] <= key[255:128];
        rkFile[1] <= key[127:0];
      end else if (rkStep) begin
        rkFile[rnd] <= rkNext;
      end
    end
  end else begin : gRkNoReset
    // Round-key file without reset; only ever read after a key_load
    always_ff @(posedge clk) begin
      if (rkLoad) begin
        rkFile[0] <= key[255:128];
        rkFile[1] <= key[127:0];
      end else if (rkStep) begin
        rkFile[rnd] <= rkNext;
      end
    end
  end

endmodule
